// File: rtl/yolo_pkg.sv
// Shared float32 and AXI-Stream definitions for the YOLO datapath blocks.
package yolo_pkg;

  localparam int unsigned FP32_W = 32;

  typedef logic [FP32_W-1:0] fp32;

  localparam logic [3:0] AXIS_KEEP_ALL = 4'hF;

  // Maps an IEEE-754 single to an unsigned key whose integer order matches float order.
  // Negative values are bit-inverted so larger magnitudes sort lower; positives get the
  // sign bit set so every positive sorts above every negative (+0 above -0).
  function automatic fp32 fp32_key(input fp32 x);
    fp32 k;
    if (x[FP32_W-1]) begin
      k = ~x;
    end else begin
      k = x | 32'h8000_0000;
    end
    return k;
  endfunction

endpackage

// File: rtl/fp32_max2.sv
// Combinational two-input float32 maximum. On equal keys the first operand wins,
// which keeps the choice deterministic for bitwise ties.
module fp32_max2
  import yolo_pkg::*;
(
  input  logic [FP32_W-1:0] a_i,
  input  logic [FP32_W-1:0] b_i,
  output logic [FP32_W-1:0] max_o
);

  fp32 key_a;
  fp32 key_b;

  // Select the operand with the larger ordering key; ties keep a_i.
  always_comb begin
    key_a = fp32_key(a_i);
    key_b = fp32_key(b_i);
    max_o = (key_b > key_a) ? b_i : a_i;
  end

endmodule

// File: rtl/maxpool2x2_stream.sv
// Float32 2x2 stride-2 max pooling over a raster-order AXI-Stream feature map.
// A pair register holds the even-column pixel, a half-width line buffer holds the
// horizontal maxima of the even row, and a single output register feeds the master side.
module maxpool2x2_stream
  import yolo_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 448,
  parameter int unsigned IMG_HEIGHT = 448,
  parameter int unsigned DATA_W     = 32
) (
  input  logic              AXIS_ACLK,
  input  logic              AXIS_ARESET,

  input  logic [DATA_W-1:0] S_AXIS_TDATA,
  input  logic              S_AXIS_TVALID,
  output logic              S_AXIS_TREADY,
  input  logic              S_AXIS_TLAST,
  input  logic [3:0]        S_AXIS_TKEEP,

  output logic [DATA_W-1:0] M_AXIS_TDATA,
  output logic              M_AXIS_TVALID,
  input  logic              M_AXIS_TREADY,
  output logic              M_AXIS_TLAST,
  output logic [3:0]        M_AXIS_TKEEP,

  output logic              FRAME_ERR
);

  localparam int unsigned ColW   = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned RowW   = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
  localparam int unsigned LbDepth = IMG_WIDTH / 2;
  localparam int unsigned LbW    = (ColW > 1) ? ColW - 1 : 1;

  localparam logic [ColW-1:0] ColLast = ColW'(IMG_WIDTH - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(IMG_HEIGHT - 1);

  // Keep is documented as don't-care on the slave side.
  logic unused_keep;
  assign unused_keep = ^S_AXIS_TKEEP;

  // Position counters
  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;

  // Even-column pixel waiting for its horizontal partner
  fp32 pair_q, pair_d;

  // Output register
  fp32  tdata_q, tdata_d;
  logic tvalid_q, tvalid_d;
  logic tlast_q, tlast_d;

  logic frame_err_q, frame_err_d;

  // Line buffer of even-row horizontal maxima; never reset, always written before read.
  fp32 linebuf_q [LbDepth];

  logic           rx;
  logic           tx;
  logic           last_pos;
  logic           odd_col;
  logic           odd_row;
  logic           emit;
  logic           lb_we;
  logic [LbW-1:0] lb_idx;
  fp32            lb_rd;
  fp32            h_max;
  fp32            v_max;

  assign S_AXIS_TREADY = !tvalid_q || M_AXIS_TREADY;
  assign rx            = S_AXIS_TVALID && S_AXIS_TREADY;
  assign tx            = tvalid_q && M_AXIS_TREADY;

  assign last_pos = (col_q == ColLast) && (row_q == RowLast);
  assign odd_col  = col_q[0];
  assign odd_row  = row_q[0];
  assign lb_idx   = LbW'(col_q >> 1);
  assign lb_rd    = linebuf_q[lb_idx];

  // Horizontal max of the pixel pair in the current row.
  fp32_max2 u_max_h (
    .a_i   (pair_q),
    .b_i   (S_AXIS_TDATA),
    .max_o (h_max)
  );

  // Vertical max of the stored even-row result and the odd-row pair.
  fp32_max2 u_max_v (
    .a_i   (lb_rd),
    .b_i   (h_max),
    .max_o (v_max)
  );

  // Decode which action the accepted beat triggers.
  always_comb begin
    emit  = rx && odd_col && odd_row;
    lb_we = rx && odd_col && !odd_row;
  end

  // Counter advance with resync on a misplaced TLAST.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (rx) begin
      if (S_AXIS_TLAST && !last_pos) begin
        col_d = '0;
        row_d = '0;
      end else if (col_q == ColLast) begin
        col_d = '0;
        row_d = (row_q == RowLast) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Pair capture and sticky framing error.
  always_comb begin
    pair_d      = pair_q;
    frame_err_d = frame_err_q;
    if (rx && !odd_col) begin
      pair_d = S_AXIS_TDATA;
    end
    // TLAST early (not at last_pos) or missing (at last_pos) are both framing errors.
    if (rx && (S_AXIS_TLAST != last_pos)) begin
      frame_err_d = 1'b1;
    end
  end

  // Output register: load on a completed window, otherwise drop the word once taken.
  always_comb begin
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    if (emit) begin
      tdata_d  = v_max;
      tvalid_d = 1'b1;
      tlast_d  = last_pos;
    end else if (tx) begin
      tvalid_d = 1'b0;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      col_q       <= '0;
      row_q       <= '0;
      pair_q      <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      pair_q      <= pair_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Line buffer write port; contents need no reset.
  always_ff @(posedge AXIS_ACLK) begin
    if (lb_we) begin
      linebuf_q[lb_idx] <= h_max;
    end
  end

  assign M_AXIS_TDATA  = tdata_q;
  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TLAST  = tlast_q;
  assign M_AXIS_TKEEP  = AXIS_KEEP_ALL;
  assign FRAME_ERR     = frame_err_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Directed scoreboard bench for maxpool2x2_stream on a 4x4 map.
module tb_maxpool2x2_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        m_tlast;
  logic [3:0]  m_tkeep;
  logic        frame_err;

  always #5 clk = ~clk;

  maxpool2x2_stream #(
    .IMG_WIDTH  (4),
    .IMG_HEIGHT (4),
    .DATA_W     (32)
  ) dut (
    .AXIS_ACLK     (clk),
    .AXIS_ARESET   (rst),
    .S_AXIS_TDATA  (s_tdata),
    .S_AXIS_TVALID (s_tvalid),
    .S_AXIS_TREADY (s_tready),
    .S_AXIS_TLAST  (s_tlast),
    .S_AXIS_TKEEP  (4'hF),
    .M_AXIS_TDATA  (m_tdata),
    .M_AXIS_TVALID (m_tvalid),
    .M_AXIS_TREADY (m_tready),
    .M_AXIS_TLAST  (m_tlast),
    .M_AXIS_TKEEP  (m_tkeep),
    .FRAME_ERR     (frame_err)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          stall_mode = 1'b0;
  bit          gaps = 1'b0;
  bit          accepted;
  bit          hold = 1'b0;
  logic [31:0] held_d;
  logic        held_l;
  logic [31:0] px [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Small integer n (0..16) to float32, optionally negated.
  function automatic logic [31:0] fp(input int n, input bit neg);
    int e;
    int man;
    if (n == 0) return {neg, 31'b0};
    e = 0;
    while ((n >> (e + 1)) != 0) e++;
    man = (n - (1 << e)) << (23 - e);
    return {neg, 8'(127 + e), 23'(man)};
  endfunction

  function automatic exp_t mk(input logic [31:0] d, input logic l);
    exp_t e;
    e.d = d;
    e.l = l;
    return e;
  endfunction

  // One clock: monitor at negedge, then advance to just after posedge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      if (hold && m_tvalid) begin
        chk("stall_data_stable", m_tdata, held_d);
        chk("stall_last_stable", 32'(m_tlast), 32'(held_l));
      end
      if (m_tvalid && m_tready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_beat: observed %h expected none", m_tdata);
        end else begin
          e = sb.pop_front();
          chk("out_data", m_tdata, e.d);
          chk("out_last", 32'(m_tlast), 32'(e.l));
        end
      end
      hold   = m_tvalid && !m_tready;
      held_d = m_tdata;
      held_l = m_tlast;
    end else begin
      hold = 1'b0;
    end
    accepted = s_tvalid && s_tready && !rst;
    @(posedge clk);
    #1;
    cyc++;
    if (stall_mode) m_tready = (cyc % 3 == 0);
  endtask

  task automatic send_pixel(input logic [31:0] d, input bit last);
    int n;
    if (gaps) repeat ($urandom_range(0, 2)) step();
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = last;
    n = 0;
    do begin
      step();
      n++;
    end while (!accepted && n < 100);
    if (!accepted) begin
      checks++;
      errors++;
      $error("FAIL accept_timeout: observed no accept expected accept of %h", d);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // Sends px[0..n-1]; TLAST on index last_idx (-1 for none).
  task automatic send_px(input int n, input int last_idx, input bit chk_lat);
    for (int i = 0; i < n; i++) begin
      send_pixel(px[i], i == last_idx);
      if (chk_lat) begin
        chk($sformatf("latency_valid_px%0d", i + 1), 32'(m_tvalid),
            32'((i == 5) || (i == 7) || (i == 13) || (i == 15)));
      end
    end
  endtask

  task automatic load_pos();
    for (int i = 0; i < 16; i++) px[i] = fp(i + 1, 1'b0);
  endtask

  task automatic push_pos();
    sb.push_back(mk(32'h40C0_0000, 1'b0));
    sb.push_back(mk(32'h4100_0000, 1'b0));
    sb.push_back(mk(32'h4160_0000, 1'b0));
    sb.push_back(mk(32'h4180_0000, 1'b1));
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      step();
      n++;
    end
    chk({tag, "_pending"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    chk("reset_tvalid", 32'(m_tvalid), 32'd0);
    rst = 1'b0;
    step();
  endtask

  initial begin
    // Reset state
    repeat (2) step();
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_tlast", 32'(m_tlast), 32'd0);
    chk("rst_tdata", m_tdata, 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    rst = 1'b0;
    step();
    chk("rst_s_tready", 32'(s_tready), 32'd1);
    chk("tkeep", 32'(m_tkeep), 32'hF);

    // Positive ramp with latency checks
    load_pos();
    push_pos();
    send_px(16, 15, 1'b1);

    // All-negative frame back-to-back
    for (int i = 0; i < 16; i++) px[i] = fp(i + 1, 1'b1);
    sb.push_back(mk(32'hBF80_0000, 1'b0));
    sb.push_back(mk(32'hC040_0000, 1'b0));
    sb.push_back(mk(32'hC110_0000, 1'b0));
    sb.push_back(mk(32'hC130_0000, 1'b1));
    send_px(16, 15, 1'b0);

    // Mixed-zero window {-0, +0, -5, -7}
    px[0] = 32'h8000_0000;
    px[1] = 32'h0000_0000;
    px[4] = fp(5, 1'b1);
    px[5] = fp(7, 1'b1);
    sb.push_back(mk(32'h0000_0000, 1'b0));
    sb.push_back(mk(32'hC040_0000, 1'b0));
    sb.push_back(mk(32'hC110_0000, 1'b0));
    sb.push_back(mk(32'hC130_0000, 1'b1));
    send_px(16, 15, 1'b0);
    drain("neg");
    chk("clean_frame_err", 32'(frame_err), 32'd0);

    // Backpressure and input gaps
    load_pos();
    push_pos();
    stall_mode = 1'b1;
    gaps       = 1'b1;
    send_px(16, 15, 1'b0);
    drain("stall");
    stall_mode = 1'b0;
    gaps       = 1'b0;
    m_tready   = 1'b1;
    step();

    // Misplaced TLAST on pixel 7, then a clean frame
    sb.push_back(mk(32'h40C0_0000, 1'b0));
    send_px(7, 6, 1'b0);
    push_pos();
    send_px(16, 15, 1'b0);
    drain("early_tlast");
    chk("early_tlast_frame_err", 32'(frame_err), 32'd1);
    pulse_reset();
    chk("frame_err_cleared", 32'(frame_err), 32'd0);

    // Missing TLAST on the final pixel
    push_pos();
    send_px(16, -1, 1'b0);
    drain("missing_tlast");
    chk("missing_tlast_frame_err", 32'(frame_err), 32'd1);
    pulse_reset();

    // Reset in the middle of a frame
    send_px(5, -1, 1'b0);
    rst = 1'b1;
    step();
    chk("midreset_tvalid_during", 32'(m_tvalid), 32'd0);
    rst = 1'b0;
    step();
    chk("midreset_tvalid_after", 32'(m_tvalid), 32'd0);
    repeat (3) step();
    chk("midreset_no_output", 32'(m_tvalid), 32'd0);
    push_pos();
    send_px(16, 15, 1'b0);
    drain("after_reset");
    chk("after_reset_frame_err", 32'(frame_err), 32'd0);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
